// File: rtl/sat_rd_pkg.sv
// sat_rd_pkg: shared types and encodings for the sat_bin result reader
//   var_state_t : decoded vars-states RAM word {value, implied, level}
//   VAL_*       : per-variable assignment encodings
//   RES_*       : solver result encodings
//   rd_state_e  : unload controller states
package sat_rd_pkg;
    localparam int LVL_W = 16;
    typedef struct packed {
        logic [1:0]       value;
        logic             implied;
        logic [LVL_W-1:0] level;
    } var_state_t;
    localparam logic [1:0] VAL_UNASSIGNED = 2'b00;
    localparam logic [1:0] VAL_FALSE      = 2'b01;
    localparam logic [1:0] VAL_TRUE       = 2'b10;
    localparam logic [1:0] RES_NONE  = 2'b00;
    localparam logic [1:0] RES_SAT   = 2'b01;
    localparam logic [1:0] RES_UNSAT = 2'b10;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_FINISH} rd_state_e;
endpackage

// File: rtl/sat_rd_skid_fifo.sv
// sat_rd_skid_fifo: 2-entry FIFO holding RAM words that the sink has not yet taken
//   clk, rst (async, active-low)
//   push/din : write an entry      pop/dout : remove the head entry
//   count, full, empty : occupancy
module sat_rd_skid_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [2];
    logic rd, wr;
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= din;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd    <= 1'b0;
            wr    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) wr <= !wr;
            if (pop) rd <= !rd;
            count <= count + 2'(push) - 2'(pop);
        end
    end
    assign dout  = mem[rd];
    assign full  = count == 2'd2;
    assign empty = count == 2'd0;
endmodule

// File: rtl/sat_bin_result_reader.sv
// sat_bin_result_reader: unloads the sat_bin vars-states RAM and streams one assignment per variable
//   clk, rst (async, active-low)
//   start_i, nv_all_i, global_sat_i, global_unsat_i : unload request, sampled on start_i
//   apply_ex_o, ram_en_vs_o, ram_addr_vs_o, ram_dout_vs_i : external vars-states read port
//   out_valid_o/out_ready_i + out_var_o, out_value_o, out_implied_o, out_level_o, out_last_o : beat stream
//   busy_o, done_o, result_o : status
//   checksum_o : XOR of delivered RAM words, present only with SAT_RD_CHECKSUM_EN defined
module sat_bin_result_reader
    import sat_rd_pkg::*;
#(
    parameter int WIDTH_VAR             = 12,
    parameter int WIDTH_LVL             = 16,
    parameter int WIDTH_VAR_STATES      = 19,
    parameter int ADDR_WIDTH_VAR_STATES = 9
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_i,
    input  logic [WIDTH_VAR-1:0]             nv_all_i,
    input  logic                             global_sat_i,
    input  logic                             global_unsat_i,
    output logic                             apply_ex_o,
    output logic                             ram_en_vs_o,
    output logic [ADDR_WIDTH_VAR_STATES-1:0] ram_addr_vs_o,
    input  logic [WIDTH_VAR_STATES-1:0]      ram_dout_vs_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [WIDTH_VAR-1:0]             out_var_o,
    output logic [1:0]                       out_value_o,
    output logic                             out_implied_o,
    output logic [WIDTH_LVL-1:0]             out_level_o,
    output logic                             out_last_o,
`ifdef SAT_RD_CHECKSUM_EN
    output logic [WIDTH_VAR_STATES-1:0]      checksum_o,
`endif
    output logic                             busy_o,
    output logic                             done_o,
    output logic [1:0]                       result_o
);
    localparam int FW = WIDTH_VAR_STATES + WIDTH_VAR + 1;
    localparam logic [WIDTH_VAR-1:0] MAX_N = WIDTH_VAR'((1 << ADDR_WIDTH_VAR_STATES) - 1);
    rd_state_e state, state_nx;
    logic [WIDTH_VAR-1:0] n, addr, pend_var, hvar;
    logic pend, pend_last, hlast;
    logic [FW-1:0] head, fifo_dout;
    logic [WIDTH_VAR_STATES-1:0] word;
    logic [1:0] count;
    logic full, empty, pop, issue, accept, skip, fifo_push;
    assign accept = state == ST_IDLE && start_i;
    assign skip   = global_unsat_i || nv_all_i == '0;
    // When the FIFO is empty the word arriving from the RAM is shown directly,
    // so a beat can leave in the same cycle its read data returns.
    assign head = empty ? {ram_dout_vs_i, pend_var, pend_last} : fifo_dout;
    assign {word, hvar, hlast} = head;
    assign out_valid_o = pend || !empty;
    assign pop   = out_valid_o && out_ready_i;
    assign issue = state == ST_READ && ({1'b0, count} + {2'b0, pend} < 3'd2 || pop);
    // An arriving word is buffered unless it leaves this cycle through the bypass.
    assign fifo_push = pend && !(empty && pop) && !full;
    sat_rd_skid_fifo #(.WIDTH(FW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (pop && !empty),
        .din   ({ram_dout_vs_i, pend_var, pend_last}),
        .dout  (fifo_dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    // A skipped unload passes through DRAIN (nothing outstanding) so done_o
    // lands two cycles after start_i.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start_i) state_nx = skip ? ST_DRAIN : ST_READ;
            ST_READ:  if (issue && addr == n) state_nx = ST_DRAIN;
            ST_DRAIN: if ((pop && hlast) || (!pend && empty)) state_nx = ST_FINISH;
            default:  state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            n         <= '0;
            addr      <= '0;
            pend      <= 1'b0;
            pend_var  <= '0;
            pend_last <= 1'b0;
            result_o  <= RES_NONE;
        end else begin
            state <= state_nx;
            pend  <= issue;
            if (issue) begin
                pend_var  <= addr;
                pend_last <= addr == n;
                addr      <= addr + 1'b1;
            end
            if (accept) begin
                n        <= nv_all_i > MAX_N ? MAX_N : nv_all_i;
                addr     <= WIDTH_VAR'(1);
                result_o <= global_sat_i ? RES_SAT : global_unsat_i ? RES_UNSAT : RES_NONE;
            end
        end
    end
`ifdef SAT_RD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) checksum_o <= '0;
        else if (accept) checksum_o <= '0;
        else if (pop) checksum_o <= checksum_o ^ word;
    end
`endif
    assign apply_ex_o    = state != ST_IDLE;
    assign busy_o        = state != ST_IDLE;
    assign done_o        = state == ST_FINISH;
    assign ram_en_vs_o   = issue;
    assign ram_addr_vs_o = addr[ADDR_WIDTH_VAR_STATES-1:0];
    assign out_var_o     = out_valid_o ? hvar : '0;
    assign out_value_o   = out_valid_o ? word[WIDTH_LVL+2:WIDTH_LVL+1] : VAL_UNASSIGNED;
    assign out_implied_o = out_valid_o && word[WIDTH_LVL];
    assign out_level_o   = out_valid_o ? word[WIDTH_LVL-1:0] : '0;
    assign out_last_o    = out_valid_o && hlast;
endmodule

// File: tb/tb_sat_bin_result_reader.sv
// tb_sat_bin_result_reader: randomized self-checking bench against a per-variable reference model
module tb_sat_bin_result_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [11:0] nv_all_i = '0;
    logic        global_sat_i = 1'b0;
    logic        global_unsat_i = 1'b0;
    logic        apply_ex_o, ram_en_vs_o;
    logic [8:0]  ram_addr_vs_o;
    logic [18:0] ram_dout_vs_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [11:0] out_var_o;
    logic [1:0]  out_value_o;
    logic        out_implied_o;
    logic [15:0] out_level_o;
    logic        out_last_o, busy_o, done_o;
    logic [1:0]  result_o;
`ifdef SAT_RD_CHECKSUM_EN
    logic [18:0] checksum_o;
`endif
    int tests = 0;
    int fails = 0;
    logic [1:0]  v_val [512];
    logic        v_imp [512];
    logic [15:0] v_lvl [512];
    logic [18:0] ram [512];

    sat_bin_result_reader dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .nv_all_i       (nv_all_i),
        .global_sat_i   (global_sat_i),
        .global_unsat_i (global_unsat_i),
        .apply_ex_o     (apply_ex_o),
        .ram_en_vs_o    (ram_en_vs_o),
        .ram_addr_vs_o  (ram_addr_vs_o),
        .ram_dout_vs_i  (ram_dout_vs_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_var_o      (out_var_o),
        .out_value_o    (out_value_o),
        .out_implied_o  (out_implied_o),
        .out_level_o    (out_level_o),
        .out_last_o     (out_last_o),
`ifdef SAT_RD_CHECKSUM_EN
        .checksum_o     (checksum_o),
`endif
        .busy_o         (busy_o),
        .done_o         (done_o),
        .result_o       (result_o)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears one cycle after the enable.
    always @(posedge clk) if (ram_en_vs_o) ram_dout_vs_i <= ram[ram_addr_vs_o];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_var(input int k, input logic [1:0] v, input logic imp, input logic [15:0] lvl);
        v_val[k] = v;
        v_imp[k] = imp;
        v_lvl[k] = lvl;
        ram[k]   = {v, imp, lvl};
    endtask

    task automatic fill_random();
        for (int a = 0; a < 512; a++)
            set_var(a, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 16'($urandom));
    endtask

    function automatic logic [47:0] all_outputs();
        return {apply_ex_o, ram_en_vs_o, ram_addr_vs_o, out_valid_o, out_var_o, out_value_o,
                out_implied_o, out_level_o, out_last_o, busy_o, done_o, result_o};
    endfunction

    // mode: 0 ready always, 1 ready pattern 1,0,0 repeating, 2 random ready
    task automatic run_unload(input int nv, input bit sat, input bit unsat, input int mode, input bit poke);
        int n_exp, k, issued, done_at, hi_addr;
        bit skip, prev_stall, busy_bad, stable_bad, occ_bad, addr_bad;
        logic [1:0]  res_exp;
        logic [18:0] csum_exp;
        logic [32:0] snap;
        skip    = unsat || nv == 0;
        n_exp   = skip ? 0 : (nv > 511 ? 511 : nv);
        res_exp = sat ? 2'b01 : unsat ? 2'b10 : 2'b00;
        csum_exp = '0;
        for (int j = 1; j <= n_exp; j++) csum_exp ^= ram[j];
        k = 1; issued = 0; done_at = 0; hi_addr = 0;
        prev_stall = 0; busy_bad = 0; stable_bad = 0; occ_bad = 0; addr_bad = 0; snap = '0;
        @(negedge clk);
        start_i = 1'b1;
        nv_all_i = 12'(nv);
        global_sat_i = sat;
        global_unsat_i = unsat;
        out_ready_i = 1'b1;
        for (int i = 1; i <= n_exp * 4 + 20 && done_at == 0; i++) begin
            @(negedge clk);
            start_i = poke && i == 3;
            if (poke && i == 3) begin
                nv_all_i = 12'd5;
                global_sat_i = 1'b0;
                global_unsat_i = 1'b1;
            end
            out_ready_i = mode == 0 ? 1'b1 : mode == 1 ? ((i - 1) % 3 == 0) : 1'($urandom_range(0, 1));
            #1;
            if (!busy_o || !apply_ex_o) busy_bad = 1;
            if (prev_stall && {out_valid_o, out_var_o, out_value_o, out_implied_o, out_level_o, out_last_o} !== snap)
                stable_bad = 1;
            if (ram_en_vs_o) begin
                if (int'(ram_addr_vs_o) != issued + 1) addr_bad = 1;
                issued++;
                if (int'(ram_addr_vs_o) > hi_addr) hi_addr = int'(ram_addr_vs_o);
            end
            if (out_valid_o && out_ready_i) begin
                if (k <= n_exp) begin
                    check("beat_var", out_var_o, k);
                    check("beat_value", out_value_o, v_val[k]);
                    check("beat_implied", out_implied_o, v_imp[k]);
                    check("beat_level", out_level_o, v_lvl[k]);
                    check("beat_last", out_last_o, k == n_exp);
                end else check("beat_overflow", k, n_exp);
                k++;
            end
            if (issued - (k - 1) > 2) occ_bad = 1;
            prev_stall = out_valid_o && !out_ready_i;
            snap = {out_valid_o, out_var_o, out_value_o, out_implied_o, out_level_o, out_last_o};
            if (done_o) done_at = i;
        end
        check("done_seen", done_at != 0, 1);
        if (mode == 0 || skip) check("done_cycle", done_at, skip ? 2 : n_exp + 2);
        check("beat_count", k - 1, n_exp);
        check("read_count", issued, n_exp);
        check("hi_addr", hi_addr, n_exp);
        check("result", result_o, res_exp);
        check("busy_window", busy_bad, 0);
        check("stall_stable", stable_bad, 0);
        check("occupancy", occ_bad, 0);
        check("addr_order", addr_bad, 0);
        check("valid_in_done", out_valid_o, 0);
`ifdef SAT_RD_CHECKSUM_EN
        check("checksum", checksum_o, csum_exp);
`endif
        @(negedge clk);
        #1;
        check("busy_after_done", busy_o, 0);
        check("done_one_cycle", done_o, 0);
        out_ready_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        fill_random();
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", all_outputs(), 0);
        rst = 1'b1;
        // directed unload from the three-variable example
        set_var(1, 2'b10, 1'b0, 16'd5);
        set_var(2, 2'b01, 1'b1, 16'd5);
        set_var(3, 2'b00, 1'b0, 16'd0);
        run_unload(3, 1, 0, 0, 0);
        fill_random();
        run_unload(4, 0, 0, 1, 0);
        run_unload(8, 0, 1, 0, 0);
        run_unload(0, 1, 0, 0, 0);
        run_unload(6, 1, 1, 0, 0);
        run_unload(600, 1, 0, 0, 0);
        run_unload(12, 0, 0, 0, 1);
`ifdef SAT_RD_CHECKSUM_EN
        set_var(1, 2'b10, 1'b1, 16'h0001);
        set_var(2, 2'b01, 1'b0, 16'h0003);
        run_unload(2, 1, 0, 0, 0);
        check("checksum_directed", checksum_o, 19'h7_0002);
`endif
        for (int r = 0; r < 6; r++) begin
            fill_random();
            run_unload($urandom_range(1, 40), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 2, 0);
        end
        // reset in the middle of an unload
        fill_random();
        @(negedge clk);
        start_i = 1'b1;
        nv_all_i = 12'd20;
        global_sat_i = 1'b1;
        global_unsat_i = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("busy_before_reset", busy_o, 1);
        rst = 1'b0;
        #1;
        check("mid_reset_outputs", all_outputs(), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("no_done_in_reset", done_o, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        run_unload(7, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
